// File: rtl/mem_access_ctrl_if.sv
// Bus between the datapath control FSM, the memory access controller and the SRAM.
// slave is the controller's view; master is the control FSM plus SRAM side.
interface mem_access_ctrl_if;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] MAR;
  logic [15:0] MDR_wdata;
  logic [15:0] MDR_In;
  logic        R;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  modport slave (
    input  req_rd, req_wr, MAR, MDR_wdata, mem_rdata,
    output MDR_In, R, busy, mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport master (
    output req_rd, req_wr, MAR, MDR_wdata, mem_rdata,
    input  MDR_In, R, busy, mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences fixed-wait SRAM reads/writes and a single
// memory-mapped I/O port (switches in, hex display out) for the datapath MDR/MAR.
module mem_access_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Reset_al,
  mem_access_ctrl_if.slave     bus,
  input  logic [15:0]          sw,
  output logic [15:0]          hex_out
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] mdr_q;
  logic [15:0] hex_q;
  logic [15:0] sw_s1_q;
  logic [15:0] sw_s2_q;
  logic        r_q;
  logic        busy_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;

  // All outputs, strobes included, come straight from flops so the SRAM sees no glitches.
  always_ff @(posedge Clk or negedge Reset_al) begin
    if (!Reset_al) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
      hex_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      r_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_rd || bus.req_wr) begin
            addr_q  <= bus.MAR;
            wdata_q <= bus.MDR_wdata;
            busy_q  <= 1'b1;
            if (bus.MAR == IO_ADDR) begin
              state_q <= DONE;
              r_q     <= 1'b1;
              if (bus.req_rd) mdr_q <= sw_s2_q;
              else            hex_q <= bus.MDR_wdata;
            end else begin
              cnt_q  <= CNT_INIT;
              ce_n_q <= 1'b0;
              // Read wins when both requests are high; the write is dropped.
              if (bus.req_rd) begin
                state_q <= RD_WAIT;
                oe_n_q  <= 1'b0;
              end else begin
                state_q <= WR_WAIT;
                we_n_q  <= 1'b0;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            mdr_q   <= bus.mem_rdata;
            state_q <= DONE;
            r_q     <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            r_q     <= 1'b1;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.MDR_In    = mdr_q;
  assign bus.R         = r_q;
  assign bus.busy      = busy_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_ce_n  = ce_n_q;
  assign bus.mem_oe_n  = oe_n_q;
  assign bus.mem_we_n  = we_n_q;
  assign hex_out       = hex_q;

endmodule
